// File: rtl/uart_mem_loader_pkg.sv
// Shared types and constants for the UART-to-RAM frame loader.
package uart_mem_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr0,
        StAddr1,
        StLen0,
        StLen1,
        StData,
        StCsum,
        StDone
    } state_e;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_CSUM  = 2'd1;
    localparam logic [1:0] ERR_RANGE = 2'd2;

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

    function automatic logic [2:0] count_lanes(input logic [3:0] mask);
        return {2'b00, mask[0]} + {2'b00, mask[1]} + {2'b00, mask[2]} + {2'b00, mask[3]};
    endfunction

endpackage

// File: rtl/uart_byte_packer.sv
// Packs a byte stream little-endian into 32-bit words; flush_o marks a word ready this cycle.
module uart_byte_packer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    input  logic        last_i,
    output logic        flush_o,
    output logic [31:0] word_o,
    output logic [3:0]  mask_o
);

    logic [1:0]  lane_q, lane_d;
    logic [31:0] asm_q, asm_d;

    always_comb begin
        flush_o = byte_valid_i & ((lane_q == 2'd3) | last_i);
        // Current byte is merged in so a flushed word includes it without an extra cycle.
        word_o  = asm_q | ({24'b0, byte_data_i} << {lane_q, 3'b000});
        unique case (lane_q)
            2'd0:    mask_o = 4'b0001;
            2'd1:    mask_o = 4'b0011;
            2'd2:    mask_o = 4'b0111;
            default: mask_o = 4'b1111;
        endcase
        lane_d = lane_q;
        asm_d  = asm_q;
        if (clear_i) begin
            lane_d = 2'd0;
            asm_d  = 32'd0;
        end else if (byte_valid_i) begin
            if (flush_o) begin
                lane_d = 2'd0;
                asm_d  = 32'd0;
            end else begin
                lane_d = lane_q + 2'd1;
                asm_d  = word_o;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lane_q <= 2'd0;
            asm_q  <= 32'd0;
        end else begin
            lane_q <= lane_d;
            asm_q  <= asm_d;
        end
    end

endmodule

// File: rtl/uart_mem_loader.sv
// Parses framed load commands from a UART byte stream and writes packed words to an Avalon-MM RAM.
module uart_mem_loader
    import uart_mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DEPTH    = 40000,
    parameter logic [7:0]  HDR_BYTE = HDR_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic [31:0]       mem_writedata,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_clken,
    output logic              busy,
    output logic              load_done,
    output logic [1:0]        load_err,
    output logic [15:0]       bytes_written
);

    localparam int unsigned AW1 = ADDR_W + 1;
    localparam logic [ADDR_W:0] DepthW = AW1'(DEPTH);

    state_e            state_q, state_d;
    // One extra bit so the address can run past the top without wrapping to 0.
    logic [ADDR_W:0]   addr_q, addr_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       remain_q, remain_d;
    logic [7:0]        sum_q, sum_d;
    logic [1:0]        err_q, err_d;
    logic [15:0]       bytes_q, bytes_d;
    logic              done_q, done_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [3:0]        wr_be_q, wr_be_d;
    logic [31:0]       wr_data_q, wr_data_d;

    logic        accept, pk_clear, pk_valid, pk_last, pk_flush;
    logic [31:0] pk_word;
    logic [3:0]  pk_mask;
    logic [15:0] len_full;

    assign rx_ready = ~reset;
    assign accept   = rx_valid & rx_ready;
    assign len_full = {rx_data, len_lo_q};

    uart_byte_packer u_packer (
        .clk_i        (clk),
        .rst_i        (reset),
        .clear_i      (pk_clear),
        .byte_valid_i (pk_valid),
        .byte_data_i  (rx_data),
        .last_i       (pk_last),
        .flush_o      (pk_flush),
        .word_o       (pk_word),
        .mask_o       (pk_mask)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_lo_d  = len_lo_q;
        remain_d  = remain_q;
        sum_d     = sum_q;
        err_d     = err_q;
        bytes_d   = bytes_q;
        done_d    = (state_q == StDone);
        wr_d      = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_be_d   = wr_be_q;
        wr_data_d = wr_data_q;
        pk_clear  = 1'b0;
        pk_valid  = 1'b0;
        pk_last   = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept && rx_data == HDR_BYTE) begin
                    state_d  = StAddr0;
                    err_d    = ERR_OK;
                    bytes_d  = 16'd0;
                    pk_clear = 1'b1;
                end
            end
            StAddr0: if (accept) begin
                addr_d  = AW1'(rx_data);
                state_d = StAddr1;
            end
            StAddr1: if (accept) begin
                addr_d  = AW1'({rx_data, addr_q[7:0]});
                state_d = StLen0;
            end
            StLen0: if (accept) begin
                len_lo_d = rx_data;
                state_d  = StLen1;
            end
            StLen1: if (accept) begin
                remain_d = len_full;
                sum_d    = 8'd0;
                state_d  = (len_full == 16'd0) ? StCsum : StData;
            end
            StData: if (accept) begin
                pk_valid = 1'b1;
                pk_last  = (remain_q == 16'd1);
                sum_d    = sum_q + rx_data;
                remain_d = remain_q - 16'd1;
                if (pk_flush) begin
                    if (err_q == ERR_RANGE || addr_q >= DepthW) begin
                        err_d = ERR_RANGE;
                    end else begin
                        wr_d      = 1'b1;
                        wr_addr_d = addr_q[ADDR_W-1:0];
                        wr_be_d   = pk_mask;
                        wr_data_d = pk_word;
                        bytes_d   = bytes_q + 16'(count_lanes(pk_mask));
                    end
                    addr_d = addr_q + 1'b1;
                end
                if (pk_last) state_d = StCsum;
            end
            StCsum: if (accept) begin
                if (rx_data != sum_q && err_q != ERR_RANGE) err_d = ERR_CSUM;
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            len_lo_q  <= 8'd0;
            remain_q  <= 16'd0;
            sum_q     <= 8'd0;
            err_q     <= ERR_OK;
            bytes_q   <= 16'd0;
            done_q    <= 1'b0;
            wr_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_be_q   <= 4'd0;
            wr_data_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_lo_q  <= len_lo_d;
            remain_q  <= remain_d;
            sum_q     <= sum_d;
            err_q     <= err_d;
            bytes_q   <= bytes_d;
            done_q    <= done_d;
            wr_q      <= wr_d;
            wr_addr_q <= wr_addr_d;
            wr_be_q   <= wr_be_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign mem_address    = wr_addr_q;
    assign mem_byteenable = wr_be_q;
    assign mem_writedata  = wr_data_q;
    assign mem_write      = wr_q;
    assign mem_chipselect = wr_q;
    assign mem_clken      = 1'b1;
    assign busy           = (state_q != StIdle);
    assign load_done      = done_q;
    assign load_err       = err_q;
    assign bytes_written  = bytes_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Self-checking bench: table-driven frames, hand-written timing/reset sequences, random frames.
module tb_uart_mem_loader;

    localparam int DEPTH = 40000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [15:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic        mem_chipselect, mem_write, mem_clken, busy, load_done;
    logic [1:0]  load_err;
    logic [15:0] bytes_written;

    uart_mem_loader #(.ADDR_W(16), .DEPTH(DEPTH), .HDR_BYTE(8'hA5)) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_writedata  (mem_writedata),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_clken      (mem_clken),
        .busy           (busy),
        .load_done      (load_done),
        .load_err       (load_err),
        .bytes_written  (bytes_written)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        time         t;
    } wr_t;

    typedef struct {
        logic [15:0] addr;
        int          len;
        bit          bad;
        logic [1:0]  err;
        int          bytes;
        int          nwr;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    time  done_t = 0;
    time  t_last_data = 0;
    time  t_csum = 0;
    wr_t  got[$];
    logic [7:0] fdata[64];
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mem_write || mem_chipselect) begin
            checks++;
            if (mem_chipselect !== mem_write) begin
                errors++;
                $display("FAIL chipselect: cs=%b wr=%b", mem_chipselect, mem_write);
            end
        end
        if (mem_write) got.push_back('{mem_address, mem_writedata, mem_byteenable, $time});
        if (load_done) begin
            done_cnt++;
            done_t = $time;
        end
    end

    task automatic put(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        rx_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [15:0] a, input int n, input bit bad, input int gmax);
        logic [7:0] s;
        int d0;
        int waited;
        s  = 8'd0;
        d0 = done_cnt;
        got.delete();
        put(8'hA5);
        chk("busy_after_hdr", 32'(busy), 32'd1);
        put(a[7:0]);
        put(a[15:8]);
        put(n[7:0]);
        put(n[15:8]);
        for (int k = 0; k < n; k++) begin
            put(fdata[k]);
            s = s + fdata[k];
            t_last_data = $time - 1;
            gap($urandom_range(gmax, 0));
        end
        put(bad ? s + 8'd1 : s);
        t_csum = $time - 1;
        rx_valid = 1'b0;
        waited = 0;
        while (done_cnt == d0 && waited < 8) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("load_done_pulses", 32'(done_cnt - d0), 32'd1);
        gap(2);
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    // Reference: words are computed straight from the frame contents and the address range rule.
    task automatic check_frame(input logic [15:0] a, input int n, input bit bad);
        wr_t exp[$];
        bit range;
        int exp_bytes;
        int waddr;
        wr_t w;
        range = 0;
        exp_bytes = 0;
        for (int wi = 0; wi < (n + 3) / 4; wi++) begin
            waddr = int'(a) + wi;
            if (range || waddr >= DEPTH) begin
                range = 1;
            end else begin
                w.addr = 16'(waddr);
                w.data = 32'd0;
                w.be   = 4'd0;
                w.t    = 0;
                for (int j = 0; j < 4; j++) begin
                    if (4 * wi + j < n) begin
                        w.data[8*j +: 8] = fdata[4*wi + j];
                        w.be[j] = 1'b1;
                        exp_bytes++;
                    end
                end
                exp.push_back(w);
            end
        end
        chk("num_writes", 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            chk("wr_addr", 32'(got[i].addr), 32'(exp[i].addr));
            chk("wr_data", got[i].data, exp[i].data);
            chk("wr_be", 32'(got[i].be), 32'(exp[i].be));
        end
        chk("load_err", 32'(load_err), range ? 32'd2 : (bad ? 32'd1 : 32'd0));
        chk("bytes_written", 32'(bytes_written), 32'(exp_bytes));
    endtask

    initial begin
        vecs[0] = '{16'h0010, 8, 1'b0, 2'd0, 8, 2};
        vecs[1] = '{16'h0000, 5, 1'b0, 2'd0, 5, 2};
        vecs[2] = '{16'h0010, 8, 1'b1, 2'd1, 8, 2};
        vecs[3] = '{16'h9C3F, 8, 1'b0, 2'd2, 4, 1};
        vecs[4] = '{16'h0100, 0, 1'b0, 2'd0, 0, 0};
        vecs[5] = '{16'h9C40, 4, 1'b0, 2'd2, 0, 0};
        vecs[6] = '{16'h9C3F, 8, 1'b1, 2'd2, 4, 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_clken", 32'(mem_clken), 32'd1);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_bytes", 32'(bytes_written), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rx_ready_after_rst", 32'(rx_ready), 32'd1);

        for (int k = 0; k < 64; k++) fdata[k] = 8'(k + 1);

        // Table-driven frames
        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].addr, vecs[v].len, vecs[v].bad, 1);
            chk("tbl_err", 32'(load_err), 32'(vecs[v].err));
            chk("tbl_bytes", 32'(bytes_written), 32'(vecs[v].bytes));
            chk("tbl_nwr", 32'(got.size()), 32'(vecs[v].nwr));
            check_frame(vecs[v].addr, vecs[v].len, vecs[v].bad);
            if (v == 1 && got.size() == 2) begin
                chk("n5_last_data", got[1].data, 32'h0000_0005);
                chk("n5_last_be", 32'(got[1].be), 32'h1);
            end
        end

        // Garbage then a back-to-back frame: timing and spacing
        put(8'h00);
        put(8'h5A);
        put(8'hFF);
        put(8'hA4);
        send_frame(16'h0010, 8, 1'b0, 0);
        check_frame(16'h0010, 8, 1'b0);
        chk("b2b_nwr", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("b2b_word0", got[0].data, 32'h0403_0201);
            chk("b2b_addr1", 32'(got[1].addr), 32'h0011);
            chk("b2b_spacing", 32'(got[1].t - got[0].t), 32'd40);
            chk("b2b_wr_latency", 32'(got[1].t - t_last_data), 32'd5);
        end
        chk("b2b_done_latency", 32'(done_t - t_csum), 32'd15);

        // Reset after three data bytes
        got.delete();
        put(8'hA5);
        put(8'h00);
        put(8'h02);
        put(8'h08);
        put(8'h00);
        put(8'h11);
        put(8'h22);
        put(8'h33);
        rx_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_rx_ready", 32'(rx_ready), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        gap(6);
        chk("midrst_no_write", 32'(got.size()), 32'd0);
        send_frame(16'h0200, 8, 1'b0, 1);
        check_frame(16'h0200, 8, 1'b0);

        // Random frames against the reference
        for (int r = 0; r < 25; r++) begin
            logic [15:0] a;
            int n;
            bit bad;
            a   = ($urandom_range(1, 0) == 1) ? 16'($urandom_range(1000, 0))
                                              : 16'($urandom_range(DEPTH + 2, DEPTH - 6));
            n   = $urandom_range(20, 0);
            bad = 1'($urandom_range(1, 0));
            for (int k = 0; k < 64; k++) fdata[k] = 8'($urandom);
            send_frame(a, n, bad, 2);
            check_frame(a, n, bad);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
